// File: rtl/trap_ctrl.sv
// trap_ctrl: sequencer between decode/execute and the machine CSR file.
// Takes one system op at a time (ecall, mret, csrrw, csrrs), drives the CSR file's
// single write port and read address over several cycles, and returns rd write-back
// data and a fetch redirect.
// Optional build macro: MSTATUS_UPDATE_EN -- when defined, ecall and mret also
// read-modify-write mstatus (MIE/MPIE/MPP stacking); otherwise mstatus is untouched.
module trap_ctrl #(
  parameter int          CSR_AW      = 12,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_ecall,
  input  logic              op_mret,
  input  logic              op_csrrw,
  input  logic              op_csrrs,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_rs1,
  input  logic              in_rs1_zero,
  input  logic [CSR_AW-1:0] in_csr_addr,
  output logic [CSR_AW-1:0] csr_read_addr,
  input  logic [31:0]       csr_rdata,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [31:0]       csr_wdata,
  output logic              done,
  output logic              rd_we,
  output logic [31:0]       rd_data,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
);

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

  typedef enum logic [3:0] {
    IDLE, CSR_OP, T_EPC, T_CAUSE, T_STAT, T_JUMP, R_STAT, R_JUMP, NOP_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, rs1_q;
  logic                rs1_zero_q, is_rs_q;
  logic [CSR_AW-1:0]   addr_q;
  logic                accept;

`ifdef MSTATUS_UPDATE_EN
  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M-mode (only mode implemented).
  function automatic logic [31:0] mstatus_ret(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction
`endif

  assign accept = in_valid & in_ready;

  // Operand capture on accept; later input changes are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      rs1_q      <= '0;
      rs1_zero_q <= 1'b0;
      is_rs_q    <= 1'b0;
      addr_q     <= '0;
    end else if (accept) begin
      pc_q       <= in_pc & 32'hFFFF_FFFC;
      rs1_q      <= in_rs1;
      rs1_zero_q <= in_rs1_zero;
      is_rs_q    <= op_csrrs & ~op_csrrw;
      addr_q     <= in_csr_addr;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and all outputs; everything is forced quiet while rst is high so a
  // reset mid-op issues no further write and no done.
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    csr_read_addr  = '0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_wdata      = '0;
    done           = 1'b0;
    rd_we          = 1'b0;
    rd_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (op_ecall) begin
              state_d = T_EPC;
            end else if (op_mret) begin
`ifdef MSTATUS_UPDATE_EN
              state_d = R_STAT;
`else
              state_d = R_JUMP;
`endif
            end else if (op_csrrw || op_csrrs) begin
              state_d = CSR_OP;
            end else begin
              state_d = NOP_DONE;
            end
          end
        end
        CSR_OP: begin
          csr_read_addr = addr_q;
          rd_data       = csr_rdata;
          rd_we         = 1'b1;
          done          = 1'b1;
          if (!is_rs_q) begin
            csr_write      = 1'b1;
            csr_write_addr = addr_q;
            csr_wdata      = rs1_q;
          end else if (!rs1_zero_q) begin
            csr_write      = 1'b1;
            csr_write_addr = addr_q;
            csr_wdata      = csr_rdata | rs1_q;
          end
          state_d = IDLE;
        end
        T_EPC: begin
          csr_write      = 1'b1;
          csr_write_addr = CSR_MEPC;
          csr_wdata      = pc_q;
          state_d        = T_CAUSE;
        end
        T_CAUSE: begin
          csr_write      = 1'b1;
          csr_write_addr = CSR_MCAUSE;
          csr_wdata      = ECALL_CAUSE;
`ifdef MSTATUS_UPDATE_EN
          state_d        = T_STAT;
`else
          state_d        = T_JUMP;
`endif
        end
`ifdef MSTATUS_UPDATE_EN
        T_STAT: begin
          csr_read_addr  = CSR_MSTATUS;
          csr_write      = 1'b1;
          csr_write_addr = CSR_MSTATUS;
          csr_wdata      = mstatus_trap(csr_rdata);
          state_d        = T_JUMP;
        end
        R_STAT: begin
          csr_read_addr  = CSR_MSTATUS;
          csr_write      = 1'b1;
          csr_write_addr = CSR_MSTATUS;
          csr_wdata      = mstatus_ret(csr_rdata);
          state_d        = R_JUMP;
        end
`endif
        T_JUMP: begin
          csr_read_addr  = CSR_MTVEC;
          redirect_pc    = {csr_rdata[31:2], 2'b00};
          redirect_valid = 1'b1;
          done           = 1'b1;
          state_d        = IDLE;
        end
        R_JUMP: begin
          csr_read_addr  = CSR_MEPC;
          redirect_pc    = csr_rdata;
          redirect_valid = 1'b1;
          done           = 1'b1;
          state_d        = IDLE;
        end
        NOP_DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Testbench for trap_ctrl: directed vector table, a few hand sequences for
// back-to-back issue and mid-op reset, then random ops against a reference model.
module tb_trap_ctrl;

`ifdef MSTATUS_UPDATE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_SCR     = 12'h340;
  localparam logic [11:0] A_MIE     = 12'h304;

  logic        clk, rst, in_valid, in_ready;
  logic        op_ecall, op_mret, op_csrrw, op_csrrs;
  logic [31:0] in_pc, in_rs1;
  logic        in_rs1_zero;
  logic [11:0] in_csr_addr, csr_read_addr, csr_write_addr;
  logic [31:0] csr_rdata, csr_wdata, rd_data, redirect_pc;
  logic        csr_write, done, rd_we, redirect_valid;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_ecall(op_ecall), .op_mret(op_mret), .op_csrrw(op_csrrw), .op_csrrs(op_csrrs),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs1_zero(in_rs1_zero), .in_csr_addr(in_csr_addr),
    .csr_read_addr(csr_read_addr), .csr_rdata(csr_rdata), .csr_write(csr_write),
    .csr_write_addr(csr_write_addr), .csr_wdata(csr_wdata), .done(done), .rd_we(rd_we),
    .rd_data(rd_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file environment: combinational read, write on clock edge.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  assign csr_rdata = mem[csr_read_addr];
  always @(posedge clk) if (csr_write) mem[csr_write_addr] <= csr_wdata;

  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];

  // Every write the DUT issues, in order.
  always @(negedge clk) if (csr_write) got_q.push_back('{a: csr_write_addr, d: csr_wdata});

  typedef struct {
    logic [3:0]  ops;   // {ecall, mret, csrrw, csrrs}
    logic [31:0] pc;
    logic [31:0] rs1;
    logic        rz;
    logic [11:0] addr;
    int          lat;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  logic [31:0] refm [0:4095];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] ops, input logic [31:0] pc, input logic [31:0] rs1,
                              input logic rz, input logic [11:0] addr, input int lat,
                              input logic rwe, input logic [31:0] rdd, input logic rdr,
                              input logic [31:0] rpc);
    vec_t v;
    v.ops = ops; v.pc = pc; v.rs1 = rs1; v.rz = rz; v.addr = addr; v.lat = lat;
    v.rd_we = rwe; v.rd_data = rdd; v.redir = rdr; v.rpc = rpc;
    return v;
  endfunction

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
    refm[a] = d;
  endtask

  // Reference model: architectural effect of one op, from the ISA rules.
  task automatic predict(input vec_t v, output vec_t r);
    logic [31:0] old, s;
    r = v; r.lat = 1; r.rd_we = 0; r.rd_data = 0; r.redir = 0; r.rpc = 0;
    exp_q.delete();
    if (v.ops[3]) begin
      push_wr(A_MEPC, v.pc & ~32'h3);
      push_wr(A_MCAUSE, 32'd11);
      if (EN) begin
        s = refm[A_MSTATUS];
        push_wr(A_MSTATUS, (s & ~32'h1888) | ((s & 32'h8) << 4) | 32'h1800);
      end
      r.redir = 1; r.rpc = refm[A_MTVEC] & ~32'h3; r.lat = EN ? 4 : 3;
    end else if (v.ops[2]) begin
      if (EN) begin
        s = refm[A_MSTATUS];
        push_wr(A_MSTATUS, (s & ~32'h1888) | ((s & 32'h80) >> 4) | 32'h1880);
      end
      r.redir = 1; r.rpc = refm[A_MEPC]; r.lat = EN ? 2 : 1;
    end else if (v.ops[1]) begin
      old = refm[v.addr];
      push_wr(v.addr, v.rs1);
      r.rd_we = 1; r.rd_data = old;
    end else if (v.ops[0]) begin
      old = refm[v.addr];
      if (!v.rz) push_wr(v.addr, old | v.rs1);
      r.rd_we = 1; r.rd_data = old;
    end
  endtask

  task automatic drive(input vec_t v);
    {op_ecall, op_mret, op_csrrw, op_csrrs} = v.ops;
    in_pc = v.pc; in_rs1 = v.rs1; in_rs1_zero = v.rz; in_csr_addr = v.addr;
  endtask

  task automatic drive_junk();
    {op_ecall, op_mret, op_csrrw, op_csrrs} = 4'($urandom);
    in_pc = $urandom; in_rs1 = $urandom; in_rs1_zero = 1'($urandom); in_csr_addr = 12'($urandom);
  endtask

  task automatic check_csrs(input string tag);
    chk({tag, " mstatus"}, mem[A_MSTATUS], refm[A_MSTATUS]);
    chk({tag, " mtvec"},   mem[A_MTVEC],   refm[A_MTVEC]);
    chk({tag, " mepc"},    mem[A_MEPC],    refm[A_MEPC]);
    chk({tag, " mcause"},  mem[A_MCAUSE],  refm[A_MCAUSE]);
    chk({tag, " mscratch"}, mem[A_SCR],    refm[A_SCR]);
  endtask

  // Issue one op and compare handshake, latency, results and the write sequence.
  task automatic run_op(input vec_t st, input vec_t ex, input string tag);
    vec_t pv;
    int base, lat, ng, ne;
    bit seen;
    @(negedge clk);
    base = got_q.size();
    predict(st, pv);
    chk({tag, " ready"}, 32'(in_ready), 32'd1);
    drive(st);
    in_valid = 1'b1;
    seen = 0; lat = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin in_valid = 1'b0; drive_junk(); end
      if (done === 1'b1) begin seen = 1; lat = n; end
      else chk({tag, " busy_ready"}, 32'(in_ready), 32'd0);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within 8 cycles, expected latency %0d", tag, ex.lat);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(ex.lat));
      chk({tag, " rd_we"}, 32'(rd_we), 32'(ex.rd_we));
      chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'(ex.redir));
      if (ex.rd_we) chk({tag, " rd_data"}, rd_data, ex.rd_data);
      if (ex.redir) chk({tag, " redirect_pc"}, redirect_pc, ex.rpc);
    end
    #1;
    ng = got_q.size() - base;
    ne = exp_q.size();
    chk({tag, " write_count"}, 32'(ng), 32'(ne));
    for (int i = 0; i < ng && i < ne; i++) begin
      chk({tag, " write_addr"}, 32'(got_q[base+i].a), 32'(exp_q[i].a));
      chk({tag, " write_data"}, got_q[base+i].d, exp_q[i].d);
    end
    @(posedge clk); #1;
    check_csrs(tag);
  endtask

  vec_t tbl[$];
  vec_t pv, rv, r2;
  int base;

  initial begin
    for (int i = 0; i < 4096; i++) refm[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0;
    op_ecall = 0; op_mret = 0; op_csrrw = 0; op_csrrs = 0;
    in_pc = 0; in_rs1 = 0; in_rs1_zero = 0; in_csr_addr = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst csr_write", 32'(csr_write), 32'd0);
    chk("rst rd_we", 32'(rd_we), 32'd0);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst csr_wdata", csr_wdata, 32'd0);
    chk("rst addrs", 32'({csr_read_addr, csr_write_addr}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: {ops, pc, rs1, rs1_zero, addr} -> {latency, rd_we, rd_data, redirect, pc}.
    tbl.push_back(mk(4'b0010, 0, 32'h8000_0100, 0, A_MTVEC,   1, 1, 32'h0,         0, 0));
    tbl.push_back(mk(4'b0001, 0, 32'h0000_FFFF, 1, A_MTVEC,   1, 1, 32'h8000_0100, 0, 0));
    tbl.push_back(mk(4'b0010, 0, 32'h0000_1800, 0, A_MSTATUS, 1, 1, 32'h0,         0, 0));
    tbl.push_back(mk(4'b0001, 0, 32'h0000_0008, 1, A_MSTATUS, 1, 1, 32'h1800,      0, 0));
    tbl.push_back(mk(4'b0010, 0, 32'h8000_0103, 0, A_MTVEC,   1, 1, 32'h8000_0100, 0, 0));
    tbl.push_back(mk(4'b1000, 32'h8000_0040, 0, 0, 12'h0, EN ? 4 : 3, 0, 0, 1, 32'h8000_0100));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_MEPC,   1, 1, 32'h8000_0040, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_MCAUSE, 1, 1, 32'd11,        0, 0));
    tbl.push_back(mk(4'b0010, 0, 32'h8000_0044, 0, A_MEPC, 1, 1, 32'h8000_0040, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 12'h0, EN ? 2 : 1, 0, 0, 1, 32'h8000_0044));
    tbl.push_back(mk(4'b0000, 32'h1234, 32'h55, 0, A_MTVEC, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0010, 0, 32'h8, 0, A_MSTATUS, 1, 1, EN ? 32'h1880 : 32'h1800, 0, 0));
    tbl.push_back(mk(4'b1000, 32'h8000_0042, 0, 0, 12'h0, EN ? 4 : 3, 0, 0, 1, 32'h8000_0100));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_MSTATUS, 1, 1, EN ? 32'h1880 : 32'h8, 0, 0));
    tbl.push_back(mk(4'b0100, 0, 0, 0, 12'h0, EN ? 2 : 1, 0, 0, 1, 32'h8000_0040));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_MSTATUS, 1, 1, EN ? 32'h1888 : 32'h8, 0, 0));
    tbl.push_back(mk(4'b0011, 0, 32'h5, 0, A_SCR, 1, 1, 32'h0, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 32'h30, 0, A_SCR, 1, 1, 32'h5, 0, 0));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_SCR, 1, 1, 32'h35, 0, 0));
    tbl.push_back(mk(4'b1110, 32'h8000_0050, 0, 0, A_SCR, EN ? 4 : 3, 0, 0, 1, 32'h8000_0100));
    tbl.push_back(mk(4'b0111, 0, 32'hFF, 0, A_SCR, EN ? 2 : 1, 0, 0, 1, 32'h8000_0050));
    tbl.push_back(mk(4'b0001, 0, 0, 1, A_SCR, 1, 1, 32'h35, 0, 0));
    for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: second op offered while the first completes, accepted right after.
    @(negedge clk);
    base = got_q.size();
    rv = mk(4'b0010, 0, 32'hA5A5_0001, 0, A_MIE, 1, 1, 0, 0, 0);
    predict(rv, pv);
    drive(rv); in_valid = 1'b1;
    @(negedge clk);
    chk("b2b done1", 32'(done), 32'd1);
    chk("b2b rd1", rd_data, 32'h0);
    rv = mk(4'b0001, 0, 0, 1, A_MIE, 1, 1, 0, 0, 0);
    predict(rv, r2);
    drive(rv);
    @(negedge clk);
    chk("b2b ready", 32'(in_ready), 32'd1);
    chk("b2b gap_done", 32'(done), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b done2", 32'(done), 32'd1);
    chk("b2b rd2", rd_data, 32'hA5A5_0001);
    #1 chk("b2b writes", 32'(got_q.size() - base), 32'd1);
    @(posedge clk); #1;

    // Reset while in T_CAUSE: mepc already written, no mcause write, no done.
    @(negedge clk);
    base = got_q.size();
    drive(mk(4'b1000, 32'h8000_0060, 0, 0, 12'h0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; drive_junk();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst csr_write", 32'(csr_write), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst after done", 32'(done), 32'd0);
    chk("midrst after ready", 32'(in_ready), 32'd1);
    chk("midrst writes", 32'(got_q.size() - base), 32'd1);
    refm[A_MEPC] = 32'h8000_0060;
    run_op(mk(4'b0001, 0, 0, 1, A_MCAUSE, 1, 1, 0, 0, 0),
           mk(4'b0001, 0, 0, 1, A_MCAUSE, 1, 1, 32'd11, 0, 0), "midrst mcause");
    run_op(mk(4'b0001, 0, 0, 1, A_MEPC, 1, 1, 0, 0, 0),
           mk(4'b0001, 0, 0, 1, A_MEPC, 1, 1, 32'h8000_0060, 0, 0), "midrst mepc");

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [11:0] addrs [6];
      addrs = '{A_MSTATUS, A_MTVEC, A_MEPC, A_MCAUSE, A_SCR, A_MIE};
      rv.ops  = (($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3)));
      rv.pc   = $urandom;
      rv.rs1  = $urandom;
      rv.rz   = 1'($urandom_range(0, 2) == 0);
      rv.addr = addrs[$urandom_range(0, 5)];
      rv.lat = 0; rv.rd_we = 0; rv.rd_data = 0; rv.redir = 0; rv.rpc = 0;
      // Expectation from the model's state before this op is issued.
      begin
        logic [31:0] snap [0:4095];
        snap = refm;
        predict(rv, pv);
        refm = snap;
      end
      run_op(rv, pv, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
